// File: rtl/weight_fetch_sched.sv
// Weight fetch scheduler: streams a layer's 3x3 kernels from the weight ROM in groups of NUM_MAC slots.
// Group ready NUM_MAC+2 cycles after start/next; the held group stays stable until the consumer pulses i_next.
module weight_fetch_sched #(
  parameter int KERNEL_WIDTH = 72,
  parameter int NUM_MAC      = 12,
  parameter int BUFF_ADDR_W  = 12
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_start,
  input  logic [1:0]                       i_layer,
  input  logic                             i_next,
  output logic                             o_rom_cs,
  output logic [BUFF_ADDR_W-1:0]           o_rom_addr,
  input  logic [KERNEL_WIDTH-1:0]          i_rom_rdata,
  output logic [NUM_MAC*KERNEL_WIDTH-1:0]  o_kernel,
  output logic                             o_kernel_vld,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int SLOT_W = (NUM_MAC > 1) ? $clog2(NUM_MAC) : 1;
  localparam int GRP_W  = $clog2(NUM_MAC + 1);
  localparam int CNT_W  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                          state_q;
  logic [CNT_W-1:0]                base_q;
  logic [CNT_W-1:0]                count_q;
  logic [CNT_W-1:0]                word_cnt_q;
  logic [GRP_W-1:0]                grp_cnt_q;
  logic                            cs_q;
  logic [BUFF_ADDR_W-1:0]          addr_q;
  logic [SLOT_W-1:0]               rd_slot_q;
  logic [SLOT_W-1:0]               pend_slot_q;
  logic                            rd_pend_q;
  logic [NUM_MAC*KERNEL_WIDTH-1:0] kernel_q;
  logic                            vld_q;
  logic                            done_q;

  logic [CNT_W-1:0]                layer_base_d;
  logic [CNT_W-1:0]                layer_count_d;
  logic                            layer_ok_d;
  logic [CNT_W-1:0]                fetch_addr_d;
  logic                            issue_d;

  always_comb begin
    layer_base_d  = '0;
    layer_count_d = '0;
    layer_ok_d    = 1'b1;
    case (i_layer)
      2'd0:    begin layer_base_d = 12'd0;   layer_count_d = 12'd48;   end
      2'd1:    begin layer_base_d = 12'd48;  layer_count_d = 12'd512;  end
      2'd2:    begin layer_base_d = 12'd560; layer_count_d = 12'd2048; end
      default: layer_ok_d = 1'b0;
    endcase
  end

  assign fetch_addr_d = base_q + word_cnt_q;
  // A group ends either when all slots are issued or the layer runs out of words.
  assign issue_d      = (grp_cnt_q < GRP_W'(NUM_MAC)) && (word_cnt_q < count_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      word_cnt_q  <= '0;
      grp_cnt_q   <= '0;
      cs_q        <= 1'b0;
      addr_q      <= '0;
      rd_slot_q   <= '0;
      pend_slot_q <= '0;
      rd_pend_q   <= 1'b0;
      kernel_q    <= '0;
      vld_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      rd_pend_q   <= cs_q;
      pend_slot_q <= rd_slot_q;
      case (state_q)
        IDLE: begin
          if (i_start && layer_ok_d) begin
            base_q     <= layer_base_d;
            count_q    <= layer_count_d;
            word_cnt_q <= '0;
            grp_cnt_q  <= '0;
            kernel_q   <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (issue_d) begin
            cs_q       <= 1'b1;
            addr_q     <= BUFF_ADDR_W'(fetch_addr_d);
            rd_slot_q  <= SLOT_W'(grp_cnt_q);
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            grp_cnt_q  <= grp_cnt_q + GRP_W'(1);
          end else begin
            cs_q    <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          vld_q   <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (i_next) begin
            vld_q <= 1'b0;
            if (word_cnt_q < count_q) begin
              grp_cnt_q <= '0;
              kernel_q  <= '0;
              state_q   <= FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // ROM data lands one cycle after its chip-select cycle; steer it to the slot it was issued for.
      for (int k = 0; k < NUM_MAC; k++) begin
        if (rd_pend_q && (pend_slot_q == SLOT_W'(k))) begin
          kernel_q[k*KERNEL_WIDTH +: KERNEL_WIDTH] <= i_rom_rdata;
        end
      end
    end
  end

  assign o_rom_cs     = cs_q;
  assign o_rom_addr   = addr_q;
  assign o_kernel     = kernel_q;
  assign o_kernel_vld = vld_q;
  assign o_busy       = (state_q != IDLE);
  assign o_done       = done_q;

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Bench for weight_fetch_sched: random ROM contents, layer runs checked against a group/slot model.
module tb_weight_fetch_sched;

  localparam int KW = 72;
  localparam int NM = 12;
  localparam int AW = 12;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_start;
  logic [1:0]       i_layer;
  logic             i_next;
  logic             o_rom_cs;
  logic [AW-1:0]    o_rom_addr;
  logic [KW-1:0]    i_rom_rdata;
  logic [NM*KW-1:0] o_kernel;
  logic             o_kernel_vld;
  logic             o_busy;
  logic             o_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [AW-1:0] seen_addr[$];
  logic [KW-1:0] rom [0:4095];

  weight_fetch_sched #(.KERNEL_WIDTH(KW), .NUM_MAC(NM), .BUFF_ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_layer(i_layer), .i_next(i_next),
    .o_rom_cs(o_rom_cs), .o_rom_addr(o_rom_addr), .i_rom_rdata(i_rom_rdata),
    .o_kernel(o_kernel), .o_kernel_vld(o_kernel_vld), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rom_cs === 1'b1) i_rom_rdata <= rom[o_rom_addr];
  end

  always @(negedge clk) begin
    if (o_rom_cs === 1'b1) seen_addr.push_back(o_rom_addr);
    if (o_done === 1'b1) done_cnt = done_cnt + 1;
  end

  function automatic int layer_base(input int l);
    case (l)
      0: return 0;
      1: return 48;
      default: return 560;
    endcase
  endfunction

  function automatic int layer_count(input int l);
    case (l)
      0: return 48;
      1: return 512;
      default: return 2048;
    endcase
  endfunction

  // Expected contents of group g: ROM words in order, zero past the end of the layer.
  function automatic logic [NM*KW-1:0] model_kernel(input int base, input int cnt, input int g);
    logic [NM*KW-1:0] k_exp;
    k_exp = '0;
    for (int k = 0; k < NM; k++)
      if (g*NM + k < cnt) k_exp[k*KW +: KW] = rom[base + g*NM + k];
    return k_exp;
  endfunction

  task automatic start_layer(input logic [1:0] l);
    i_layer = l;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic take_group();
    i_next = 1'b1;
    @(posedge clk); #1;
    i_next = 1'b0;
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (o_kernel_vld !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_start = 1'b0; i_layer = 2'd0; i_next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o_rom_cs !== 1'b0) begin n_bad++; $display("FAIL reset_cs: got %b want 0", o_rom_cs); end
    n_cmp++; if (o_rom_addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", o_rom_addr); end
    n_cmp++; if (o_kernel !== '0) begin n_bad++; $display("FAIL reset_kernel: got nonzero want 0"); end
    n_cmp++; if (o_kernel_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", o_kernel_vld); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    rstn = 1'b1;
    seen_addr.delete();
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (seen_addr.size() != 0) begin n_bad++; $display("FAIL reset_no_access: got %0d reads want 0", seen_addr.size()); end
  endtask

  task automatic test_reserved_layer();
    seen_addr.delete();
    start_layer(2'd3);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reserved_busy: got %b want 0", o_busy); end
    n_cmp++; if (seen_addr.size() != 0) begin n_bad++; $display("FAIL reserved_cs: got %0d reads want 0", seen_addr.size()); end
    n_cmp++; if (o_kernel_vld !== 1'b0) begin n_bad++; $display("FAIL reserved_vld: got %b want 0", o_kernel_vld); end
  endtask

  task automatic test_full_layer(input logic [1:0] l, input bit hold_next);
    int base, cnt, ngrp, n, lat, slot, first_a;
    bit bad;
    logic [NM*KW-1:0] k_exp;
    base = layer_base(int'(l));
    cnt  = layer_count(int'(l));
    ngrp = (cnt + NM - 1) / NM;
    seen_addr.delete();
    done_cnt = 0;
    if (hold_next) i_next = 1'b1;
    start_layer(l);
    for (int g = 0; g < ngrp; g++) begin
      n = (cnt - g*NM < NM) ? (cnt - g*NM) : NM;
      wait_vld(lat);
      n_cmp++;
      if (lat != n + 2) begin
        n_bad++;
        $display("FAIL latency layer%0d grp%0d: got %0d cycles want %0d", l, g, lat, n + 2);
      end
      if (o_kernel_vld !== 1'b1) break;
      k_exp = model_kernel(base, cnt, g);
      n_cmp++;
      if (o_kernel !== k_exp) begin
        n_bad++;
        slot = 0;
        for (int k = NM - 1; k >= 0; k--)
          if (o_kernel[k*KW +: KW] !== k_exp[k*KW +: KW]) slot = k;
        $display("FAIL kernel layer%0d grp%0d slot%0d: got %h want %h", l, g, slot,
                 o_kernel[slot*KW +: KW], k_exp[slot*KW +: KW]);
      end
      bad = 1'b0;
      if (seen_addr.size() != n) bad = 1'b1;
      else for (int k = 0; k < n; k++) if (int'(seen_addr[k]) != base + g*NM + k) bad = 1'b1;
      first_a = (seen_addr.size() > 0) ? int'(seen_addr[0]) : -1;
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL addr_seq layer%0d grp%0d: got %0d reads from %0d want %0d reads from %0d",
                 l, g, seen_addr.size(), first_a, n, base + g*NM);
      end
      seen_addr.delete();
      n_cmp++;
      if (done_cnt != 0) begin n_bad++; $display("FAIL early_done layer%0d grp%0d: got %0d pulses want 0", l, g, done_cnt); end
      if (hold_next) begin
        @(posedge clk); #1;
      end else begin
        take_group();
      end
    end
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL done_pulse layer%0d: got %b want 1", l, o_done); end
    i_next = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL done_count layer%0d: got %0d want 1", l, done_cnt); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_layer%0d: busy got %b want 0", l, o_busy); end
    n_cmp++; if (seen_addr.size() != 0) begin n_bad++; $display("FAIL extra_reads layer%0d: got %0d want 0", l, seen_addr.size()); end
  endtask

  task automatic test_ignored_inputs();
    int lat, first_a;
    bit bad;
    logic [NM*KW-1:0] k_exp;
    seen_addr.delete();
    start_layer(2'd0);
    i_start = 1'b1; i_layer = 2'd1;
    @(posedge clk); #1;
    i_start = 1'b0; i_next = 1'b1;
    @(posedge clk); #1;
    i_next = 1'b0;
    wait_vld(lat);
    lat += 2;
    n_cmp++; if (lat != 14) begin n_bad++; $display("FAIL ign_latency: got %0d want 14", lat); end
    bad = 1'b0;
    if (seen_addr.size() != NM) bad = 1'b1;
    else for (int k = 0; k < NM; k++) if (int'(seen_addr[k]) != k) bad = 1'b1;
    first_a = (seen_addr.size() > 0) ? int'(seen_addr[0]) : -1;
    n_cmp++; if (bad) begin n_bad++; $display("FAIL ign_addr_seq: got %0d reads from %0d want 12 from 0", seen_addr.size(), first_a); end
    k_exp = model_kernel(0, 48, 0);
    n_cmp++; if (o_kernel !== k_exp) begin n_bad++; $display("FAIL ign_kernel: slot0 got %h want %h", o_kernel[KW-1:0], k_exp[KW-1:0]); end
    seen_addr.delete();
    i_start = 1'b1; i_layer = 2'd2;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (o_kernel_vld !== 1'b1) begin n_bad++; $display("FAIL hold_vld: got %b want 1", o_kernel_vld); end
    n_cmp++; if (o_kernel !== k_exp) begin n_bad++; $display("FAIL hold_stable: slot0 got %h want %h", o_kernel[KW-1:0], k_exp[KW-1:0]); end
    n_cmp++; if (seen_addr.size() != 0) begin n_bad++; $display("FAIL hold_no_reads: got %0d want 0", seen_addr.size()); end
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy: got %b want 1", o_busy); end
    do_reset();
  endtask

  task automatic test_reset_mid_fetch();
    int lat, first_a;
    bit bad;
    logic [NM*KW-1:0] k_exp;
    start_layer(2'd1);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (o_rom_cs !== 1'b1 || o_rom_addr !== 12'd52) begin
      n_bad++; $display("FAIL mid_fetch_addr: got cs=%b addr=%0d want cs=1 addr=52", o_rom_cs, o_rom_addr);
    end
    rstn = 1'b0;
    #1;
    n_cmp++; if (o_rom_cs !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cs: got %b want 0", o_rom_cs); end
    n_cmp++; if (o_rom_addr !== '0) begin n_bad++; $display("FAIL mid_rst_addr: got %0d want 0", o_rom_addr); end
    n_cmp++; if (o_kernel !== '0) begin n_bad++; $display("FAIL mid_rst_kernel: got nonzero want 0"); end
    n_cmp++; if (o_kernel_vld !== 1'b0) begin n_bad++; $display("FAIL mid_rst_vld: got %b want 0", o_kernel_vld); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done: got %b want 0", o_done); end
    @(posedge clk); #1;
    rstn = 1'b1;
    seen_addr.delete();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (seen_addr.size() != 0) begin n_bad++; $display("FAIL post_rst_reads: got %0d want 0", seen_addr.size()); end
    start_layer(2'd0);
    wait_vld(lat);
    n_cmp++; if (lat != 14) begin n_bad++; $display("FAIL restart_latency: got %0d want 14", lat); end
    bad = 1'b0;
    if (seen_addr.size() != NM) bad = 1'b1;
    else for (int k = 0; k < NM; k++) if (int'(seen_addr[k]) != k) bad = 1'b1;
    first_a = (seen_addr.size() > 0) ? int'(seen_addr[0]) : -1;
    n_cmp++; if (bad) begin n_bad++; $display("FAIL restart_addr_seq: got %0d reads from %0d want 12 from 0", seen_addr.size(), first_a); end
    k_exp = model_kernel(0, 48, 0);
    n_cmp++; if (o_kernel !== k_exp) begin n_bad++; $display("FAIL restart_kernel: slot0 got %h want %h", o_kernel[KW-1:0], k_exp[KW-1:0]); end
    do_reset();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom[a] = {$urandom, $urandom, $urandom};
    test_reset();
    test_reserved_layer();
    test_full_layer(2'd0, 1'b1);
    test_full_layer(2'd1, 1'b0);
    test_full_layer(2'd2, 1'b0);
    test_ignored_inputs();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_fetch_sched.md
WEIGHT_FETCH_SCHED -- requirements
Module: weight_fetch_sched

Interface
REQ-001 SHALL have parameter KERNEL_WIDTH, default 72, width of one 3x3 2-bit kernel word.
REQ-002 SHALL have parameter NUM_MAC, default 12, number of kernel slots per group.
REQ-003 SHALL have parameter BUFF_ADDR_W, default 12, weight ROM address width (4096 words).
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1 (rising edge), rstn input 1 (active-low, asynchronous assert).
REQ-005 SHALL have port i_start, input, 1 bit: layer fetch request.
REQ-006 SHALL have port i_layer, input, 2 bits: 0=CONV00, 1=CONV02, 2=CONV04, 3=reserved.
REQ-007 SHALL have port i_next, input, 1 bit: consumer has taken the held group.
REQ-008 SHALL have port o_rom_cs, output, 1 bit: ROM chip select.
REQ-009 SHALL have port o_rom_addr, output, BUFF_ADDR_W bits: ROM read address.
REQ-010 SHALL have port i_rom_rdata, input, KERNEL_WIDTH bits: ROM data, valid one cycle after the cs cycle.
REQ-011 SHALL have port o_kernel, output, NUM_MAC*KERNEL_WIDTH bits: slot k at bits [k*KW +: KW].
REQ-012 SHALL have port o_kernel_vld, output, 1 bit: o_kernel holds a complete group.
REQ-013 SHALL have port o_busy, output, 1 bit: state is not IDLE.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle pulse when a layer completes.

Function
REQ-015 SHALL use per-layer base/count: CONV00 0/48, CONV02 48/512, CONV04 560/2048 (ROM words).
REQ-016 SHALL implement states IDLE, FETCH, DRAIN, HOLD.
REQ-017 In IDLE, i_start=1 with i_layer<3 SHALL latch base/count, clear the word counter, and enter FETCH; with i_layer=3 it SHALL stay IDLE with no output change.
REQ-018 In FETCH, each cycle SHALL drive o_rom_cs=1, o_rom_addr=base+word_cnt, and increment word_cnt.
REQ-019 FETCH SHALL issue min(NUM_MAC, count-word_cnt) reads per group, then enter DRAIN for exactly one cycle.
REQ-020 Data returned for the read issued to slot k SHALL be written into slot k on the following edge; slots not read in a partial group SHALL hold zero.
REQ-021 After DRAIN the FSM SHALL enter HOLD with o_kernel_vld=1; o_kernel SHALL remain stable throughout HOLD.
REQ-022 For a full group, o_kernel_vld SHALL rise NUM_MAC+2 cycles after the i_start (or i_next) sampling edge.
REQ-023 In HOLD, i_next=1 SHALL drop o_kernel_vld on the next edge and, if word_cnt<count, clear all slots and re-enter FETCH.
REQ-024 In HOLD, i_next=1 when word_cnt==count SHALL return to IDLE and pulse o_done for one cycle.
REQ-025 o_rom_cs SHALL be 0 in IDLE, DRAIN and HOLD; o_rom_addr SHALL hold its last value when cs=0.
REQ-026 i_start outside IDLE SHALL be ignored; i_next outside HOLD SHALL be ignored.
REQ-027 Group counts SHALL be CONV00 4 full, CONV02 42 full + 1 of 8, CONV04 170 full + 1 of 8.
REQ-028 word_cnt SHALL be 12 bits; base+word_cnt SHALL never exceed 2607.

Reset
REQ-029 rstn=0 SHALL, at any time including mid-FETCH, force IDLE, o_rom_cs=0, o_rom_addr=0, o_kernel=0, o_kernel_vld=0, o_busy=0, o_done=0, and word_cnt=0.
REQ-030 After reset release, no ROM access SHALL occur until a valid i_start.

Verification
REQ-031 Bench SHALL cover CONV00 start, i_next held 1 in HOLD: addresses 0..47 in 4 bursts of 12; vld at cycle 14; exactly one o_done after the 4th i_next.
REQ-032 Bench SHALL cover CONV02 last group: 8 reads at 552..559; slots 8..11 are 0; o_done follows.
REQ-033 Bench SHALL cover CONV04 first group: addresses 560..571; slot k equals ROM[560+k].
REQ-034 Bench SHALL cover i_start pulsed during FETCH and HOLD, and i_next pulsed during FETCH: no effect on address sequence or state.
REQ-035 Bench SHALL cover rstn asserted on the 5th FETCH cycle of CONV02: all outputs 0 immediately; a new CONV00 start restarts at address 0.
REQ-036 Bench SHALL cover i_layer=3 with i_start: o_busy stays 0 and o_rom_cs stays 0.
